// File: rtl/maj_bist_pkg.sv
// Shared definitions for the majority-network BIST driver: FSM encodings,
// the default 51-bit LFSR feedback mask and the popcount width helper.
package maj_bist_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_APPLY  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  // x^51 + x^6 + x^3 + x + 1; the x^51 term is implied by the MSB shift-out.
  localparam logic [50:0] TAPS51 = 51'h4B;

  function automatic int popw(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/maj_popcount_ref.sv
// Combinational majority reference: y_ref = popcount(x) >= THRESH, unsigned.
module maj_popcount_ref
  import maj_bist_pkg::*;
#(
  parameter int N      = 51,
  parameter int THRESH = (N + 1) / 2
) (
  input  logic [N-1:0] x,
  output logic         y_ref
);

  localparam int PW = popw(N);

  logic [PW-1:0] cnt;

  // Written as a flat sum; synthesis rebalances it into an adder tree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + PW'(x[i]);
    end
  end

  assign y_ref = (cnt >= PW'(THRESH));

endmodule

// File: rtl/maj_bist_driver.sv
// Stimulus-and-check engine for a combinational N-input majority network:
// drives x_out, waits SETTLE_CYC cycles, samples y_in against a popcount reference.
module maj_bist_driver
  import maj_bist_pkg::*;
#(
  parameter int             N          = 51,
  parameter int             THRESH     = (N + 1) / 2,
  parameter int             SETTLE_CYC = 2,
  parameter logic [N-1:0]   LFSR_TAPS  = N'(TAPS51),
  parameter logic [N-1:0]   LFSR_SEED  = N'(1),
  parameter int             ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      num_vectors,
  output logic [N-1:0]     x_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [N-1:0]     first_fail_vec,
  output state_t           dbg_state
);

  localparam int           SW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [N-1:0] SEED_EFF = (LFSR_SEED == '0) ? N'(1) : LFSR_SEED;

  state_t        state;
  logic [N-1:0]  gen;
  logic [N-1:0]  gen_next;
  logic [31:0]   remaining;
  logic [SW-1:0] settle_cnt;
  logic          mode_q;
  logic          y_ref;

  maj_popcount_ref #(
    .N      (N),
    .THRESH (THRESH)
  ) u_ref (
    .x     (x_out),
    .y_ref (y_ref)
  );

  // Galois LFSR never reaches zero from a nonzero seed; counter wraps mod 2^N.
  always_comb begin
    gen_next = gen + N'(1);
    if (mode_q) begin
      gen_next = (gen << 1) ^ (gen[N-1] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      gen              <= '0;
      remaining        <= '0;
      settle_cnt       <= '0;
      mode_q           <= 1'b0;
      x_out            <= '0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            pass             <= 1'b0;
            mode_q           <= mode;
            gen              <= mode ? SEED_EFF : '0;
            remaining        <= num_vectors;
            state            <= (num_vectors == 32'd0) ? ST_FINISH : ST_APPLY;
          end
        end
        ST_APPLY: begin
          x_out      <= gen;
          settle_cnt <= SW'(SETTLE_CYC - 1);
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        ST_CHECK: begin
          if (y_in != y_ref) begin
            if (err_count != '1) begin
              err_count <= err_count + ERR_W'(1);
            end
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= x_out;
            end
          end
          gen       <= gen_next;
          remaining <= remaining - 32'd1;
          state     <= (remaining == 32'd1) ? ST_FINISH : ST_APPLY;
        end
        ST_FINISH: begin
          done  <= 1'b1;
          pass  <= (err_count == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_maj_bist_driver.sv
// Directed bench for maj_bist_driver: 5-bit counter-mode runs against ideal,
// stuck-at-0 and inverted majority models, a 4-bit saturating twin, and 51-bit LFSR runs.
module tb_maj_bist_driver;
  import maj_bist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 5-bit instance (a) and its 4-bit error-counter twin (c) share stimulus.
  logic        start_a = 1'b0, mode_a = 1'b0;
  logic [31:0] nv_a = '0;
  logic [4:0]  x_a, ffvec_a, x_c, ffvec_c;
  logic        y_a, busy_a, done_a, pass_a, ffv_a;
  logic        y_c, busy_c, done_c, pass_c, ffv_c;
  logic [15:0] err_a;
  logic [3:0]  err_c;
  state_t      st_a, st_c;
  int          kind_a = 0;

  // 51-bit LFSR instance (b).
  logic        start_b = 1'b0, mode_b = 1'b0;
  logic [31:0] nv_b = '0;
  logic [50:0] x_b, ffvec_b;
  logic        y_b, busy_b, done_b, pass_b, ffv_b;
  logic [15:0] err_b;
  state_t      st_b;
  int          kind_b = 0;
  logic        zero_seen_b = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  maj_bist_driver #(.N(5), .THRESH(3), .SETTLE_CYC(2), .ERR_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .num_vectors(nv_a),
    .x_out(x_a), .y_in(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a), .dbg_state(st_a)
  );

  maj_bist_driver #(.N(5), .THRESH(3), .SETTLE_CYC(2), .ERR_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .num_vectors(nv_a),
    .x_out(x_c), .y_in(y_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c), .dbg_state(st_c)
  );

  maj_bist_driver #(.N(51), .SETTLE_CYC(2), .LFSR_SEED(51'd0), .ERR_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .num_vectors(nv_b),
    .x_out(x_b), .y_in(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b), .dbg_state(st_b)
  );

  // kind: 0 ideal majority, 1 output stuck at 0, 2 inverted majority.
  function automatic logic dut5(input logic [4:0] x, input int kind);
    logic m;
    m = ($countones(x) >= 3);
    case (kind)
      1:       return 1'b0;
      2:       return ~m;
      default: return m;
    endcase
  endfunction

  always_comb begin
    y_a = dut5(x_a, kind_a);
    y_c = dut5(x_c, kind_a);
    y_b = (kind_b == 1) ? ($countones(x_b & ~51'd1) >= 26) : ($countones(x_b) >= 26);
  end

  always @(negedge clk) begin
    if (rst_n && st_b == ST_CHECK && x_b == '0) zero_seen_b = 1'b1;
  end

  function automatic logic [50:0] lfsr51_next(input logic [50:0] v);
    return {v[49:0], 1'b0} ^ (v[50] ? 51'h4B : 51'd0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a(input logic m, input logic [31:0] nv);
    @(negedge clk);
    mode_a = m; nv_a = nv; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_b(input logic m, input logic [31:0] nv);
    @(negedge clk);
    mode_b = m; nv_b = nv; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  // Counts posedges after the start-sampling edge until done is seen; -1 on timeout.
  task automatic wait_done(input int which, input int budget, output int cyc);
    int n;
    n = 0;
    cyc = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if ((which == 0 && done_a) || (which == 1 && done_b)) begin
        cyc = n;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    logic [50:0] v, last_v, first_v;
    int exp_err_b;
    logic first_found;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_x_out", x_a, 5'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_pass", pass_a, 1'b0);
    chk("rst_err", err_a, 16'd0);
    chk("rst_ffv", ffv_a, 1'b0);
    chk("rst_ffvec", ffvec_a, 5'd0);
    rst_n = 1'b1;

    // Ideal DUT, counter mode, 32 vectors.
    kind_a = 0;
    pulse_a(1'b0, 32'd32);
    chk("t1_busy", busy_a, 1'b1);
    wait_done(0, 300, cyc);
    chk("t1_latency", cyc, 129);
    chk("t1_err", err_a, 16'd0);
    chk("t1_pass", pass_a, 1'b1);
    chk("t1_ffv", ffv_a, 1'b0);
    chk("t1_x_end", x_a, 5'b11111);
    chk("t1_busy_end", busy_a, 1'b0);
    chk("t1_c_done", done_c, 1'b1);
    chk("t1_c_err", err_c, 4'd0);
    @(negedge clk);
    chk("t1_done_pulse", done_a, 1'b0);

    // Stuck-at-0 DUT: 16 codes have popcount >= 3, first is 00111.
    kind_a = 1;
    pulse_a(1'b0, 32'd32);
    wait_done(0, 300, cyc);
    chk("t2_latency", cyc, 129);
    chk("t2_err", err_a, 16'd16);
    chk("t2_pass", pass_a, 1'b0);
    chk("t2_ffv", ffv_a, 1'b1);
    chk("t2_ffvec", ffvec_a, 5'b00111);
    chk("t2_c_err_sat", err_c, 4'hF);
    chk("t2_c_pass", pass_c, 1'b0);

    // Inverted DUT: every vector mismatches.
    kind_a = 2;
    pulse_a(1'b0, 32'd32);
    wait_done(0, 300, cyc);
    chk("t3_err", err_a, 16'd32);
    chk("t3_ffv", ffv_a, 1'b1);
    chk("t3_ffvec", ffvec_a, 5'b00000);
    chk("t3_c_err_sat", err_c, 4'hF);

    // Zero-length run.
    kind_a = 0;
    pulse_a(1'b0, 32'd0);
    wait_done(0, 20, cyc);
    chk("t4_latency", cyc, 1);
    chk("t4_pass", pass_a, 1'b1);
    chk("t4_err", err_a, 16'd0);
    chk("t4_x_hold", x_a, 5'b11111);

    // A second start during a run is ignored.
    kind_a = 1;
    pulse_a(1'b0, 32'd32);
    repeat (10) @(negedge clk);
    mode_a = 1'b1; nv_a = 32'd3; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 300, cyc);
    chk("t4b_latency", cyc, 118);
    chk("t4b_err", err_a, 16'd16);
    chk("t4b_ffvec", ffvec_a, 5'b00111);
    chk("t4b_x_end", x_a, 5'b11111);

    // Reset mid-SETTLE of vector 9 in the stuck-at-0 run.
    kind_a = 1;
    pulse_a(1'b0, 32'd32);
    repeat (37) @(negedge clk);
    chk("t6_pre_state", st_a, ST_SETTLE);
    chk("t6_pre_x", x_a, 5'd9);
    chk("t6_pre_err", err_a, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_x", x_a, 5'd0);
    chk("t6_busy", busy_a, 1'b0);
    chk("t6_done", done_a, 1'b0);
    chk("t6_pass", pass_a, 1'b0);
    chk("t6_err", err_a, 16'd0);
    chk("t6_ffv", ffv_a, 1'b0);
    chk("t6_ffvec", ffvec_a, 5'd0);
    chk("t6_c_err", err_c, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_a(1'b0, 32'd32);
    wait_done(0, 300, cyc);
    chk("t6_rerun_latency", cyc, 129);
    chk("t6_rerun_err", err_a, 16'd16);
    chk("t6_rerun_ffvec", ffvec_a, 5'b00111);

    // Expected results for 1000 LFSR vectors from the forced seed 1.
    v = 51'd1;
    last_v = '0;
    first_v = '0;
    first_found = 1'b0;
    exp_err_b = 0;
    for (int i = 0; i < 1000; i++) begin
      last_v = v;
      if (v[0] && $countones(v) == 26) begin
        exp_err_b++;
        if (!first_found) begin
          first_found = 1'b1;
          first_v = v;
        end
      end
      v = lfsr51_next(v);
    end

    // 51-bit LFSR, ideal DUT.
    kind_b = 0;
    zero_seen_b = 1'b0;
    pulse_b(1'b1, 32'd1000);
    @(negedge clk);
    chk("t5_first_x", x_b, 51'd1);
    wait_done(1, 5000, cyc);
    chk("t5_latency", cyc, 4000);
    chk("t5_err", err_b, 16'd0);
    chk("t5_pass", pass_b, 1'b1);
    chk("t5_ffv", ffv_b, 1'b0);
    chk("t5_x_last", x_b, last_v);
    chk("t5_never_zero", zero_seen_b, 1'b0);

    // 51-bit LFSR, DUT with input 0 tied low.
    kind_b = 1;
    pulse_b(1'b1, 32'd1000);
    wait_done(1, 5000, cyc);
    chk("t5b_err_nonzero", (err_b != 16'd0), 1'b1);
    chk("t5b_err", err_b, 16'(exp_err_b));
    chk("t5b_ffv", ffv_b, 1'b1);
    chk("t5b_ffvec", ffvec_b, first_v);
    chk("t5b_pass", pass_b, 1'b0);
    chk("t5b_never_zero", zero_seen_b, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
